// File: rtl/alu_seq_pkg.sv
// Shared ALU control codes, sequencer command opcodes and FSM state encodings.
package alu_seq_pkg;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_NOT = 2'b11
   } alu_ctrl_e;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_AND  = 3'b010,
      OP_NOT  = 3'b011,
      OP_NEG  = 3'b100,
      OP_MUL  = 3'b101,
      OP_ILL6 = 3'b110,
      OP_ILL7 = 3'b111
   } cmd_op_e;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_EXEC = 3'd1,
      S_NEG2 = 3'd2,
      S_MUL  = 3'd3,
      S_DONE = 3'd4
   } state_e;

endpackage

// File: rtl/alu_op_sequencer.sv
// Command sequencer for the external 8-bit ALU: turns compound commands
// (ADD/SUB/AND/NOT/NEG/MUL) into one primitive ALU op per cycle.
// Optional macro ALU_SEQ_MUL_EN enables MUL; without it op 101 is illegal.
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   output logic [WIDTH-1:0] alu_inp1,
   output logic [WIDTH-1:0] alu_inp2,
   output logic [1:0]       alu_ctrl,
   input  logic [WIDTH-1:0] alu_out,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             res_zero,
   output logic             res_err
);

   // The multiply counter must be able to hold any B operand.
   if (CNT_W < WIDTH) begin : g_cnt_w_check
      $error("CNT_W must be >= WIDTH");
   end

   state_e           r_state;
   state_e           w_next_state;
   logic             r_cmd_ready;
   logic [2:0]       r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_tmp;
   logic [WIDTH-1:0] r_res_data;
   logic             r_res_zero;
   logic             r_res_err;
   logic             w_accept;
   logic             w_cmd_illegal;
`ifdef ALU_SEQ_MUL_EN
   logic [WIDTH-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;
`endif

   assign w_accept  = cmd_valid & r_cmd_ready;
   assign cmd_ready = r_cmd_ready;
   assign res_data  = r_res_data;
   assign res_zero  = r_res_zero;
   assign res_err   = r_res_err;

   // Decode opcodes that have no implementation in this build.
   always_comb begin
      w_cmd_illegal = cmd_op[2] & cmd_op[1];
`ifndef ALU_SEQ_MUL_EN
      if (cmd_op == OP_MUL) w_cmd_illegal = 1'b1;
`endif
   end

   // State register; cmd_ready is registered from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cmd_ready <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_cmd_ready <= (w_next_state == S_IDLE);
      end
   end

   // Next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_cmd_illegal) w_next_state = S_DONE;
`ifdef ALU_SEQ_MUL_EN
               else if (cmd_op == OP_MUL) w_next_state = (cmd_b == '0) ? S_DONE : S_MUL;
`endif
               else w_next_state = S_EXEC;
            end
         end
         S_EXEC:  w_next_state = (r_op == OP_NEG) ? S_NEG2 : S_DONE;
         S_NEG2:  w_next_state = S_DONE;
`ifdef ALU_SEQ_MUL_EN
         S_MUL:   if (r_cnt == CNT_W'(1)) w_next_state = S_DONE;
`endif
         S_DONE:  if (res_ready) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // ALU drive and result-valid decode from registered state only.
   always_comb begin
      res_valid = 1'b0;
      alu_inp1  = '0;
      alu_inp2  = '0;
      alu_ctrl  = ALU_ADD;
      case (r_state)
         S_EXEC: begin
            if (r_op == OP_NEG) begin
               alu_inp2 = r_a;
               alu_ctrl = ALU_NOT;
            end else begin
               alu_inp1 = r_a;
               alu_inp2 = r_b;
               alu_ctrl = r_op[1:0];
            end
         end
         S_NEG2: begin
            alu_inp1 = r_tmp;
            alu_inp2 = WIDTH'(1);
         end
`ifdef ALU_SEQ_MUL_EN
         S_MUL: begin
            alu_inp1 = r_acc;
            alu_inp2 = r_a;
         end
`endif
         S_DONE:  res_valid = 1'b1;
         default: ;
      endcase
   end

   // Operand capture, intermediate values and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_op       <= '0;
         r_a        <= '0;
         r_b        <= '0;
         r_tmp      <= '0;
         r_res_data <= '0;
         r_res_zero <= 1'b0;
         r_res_err  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
         r_acc      <= '0;
         r_cnt      <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_op <= cmd_op;
                  r_a  <= cmd_a;
                  r_b  <= cmd_b;
`ifdef ALU_SEQ_MUL_EN
                  r_acc <= '0;
                  r_cnt <= CNT_W'(cmd_b);
`endif
                  if (w_cmd_illegal) begin
                     r_res_data <= '0;
                     r_res_zero <= 1'b1;
                     r_res_err  <= 1'b1;
                  end else begin
                     r_res_err <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
                     if (cmd_op == OP_MUL && cmd_b == '0) begin
                        r_res_data <= '0;
                        r_res_zero <= 1'b1;
                     end
`endif
                  end
               end
            end
            S_EXEC: begin
               if (r_op == OP_NEG) begin
                  r_tmp <= alu_out;
               end else begin
                  r_res_data <= alu_out;
                  r_res_zero <= (alu_out == '0);
               end
            end
            S_NEG2: begin
               r_res_data <= alu_out;
               r_res_zero <= (alu_out == '0);
            end
`ifdef ALU_SEQ_MUL_EN
            S_MUL: begin
               r_acc <= alu_out;
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  r_res_data <= alu_out;
                  r_res_zero <= (alu_out == '0);
               end
            end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer with a behavioural ALU and result model.
// Honours ALU_SEQ_MUL_EN the same way as the design.
module tb_alu_op_sequencer;

   localparam int unsigned W = 8;

   logic         clk;
   logic         rst;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [2:0]   cmd_op;
   logic [W-1:0] cmd_a;
   logic [W-1:0] cmd_b;
   logic [W-1:0] alu_inp1;
   logic [W-1:0] alu_inp2;
   logic [1:0]   alu_ctrl;
   logic [W-1:0] alu_out;
   logic         res_valid;
   logic         res_ready;
   logic [W-1:0] res_data;
   logic         res_zero;
   logic         res_err;

   int n_checks;
   int n_fail;

   alu_op_sequencer #(.WIDTH(W), .CNT_W(8)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .alu_inp1  (alu_inp1),
      .alu_inp2  (alu_inp2),
      .alu_ctrl  (alu_ctrl),
      .alu_out   (alu_out),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_zero  (res_zero),
      .res_err   (res_err)
   );

   // External ALU: combinational, NOT acts on operand 2.
   always_comb begin
      case (alu_ctrl)
         2'b00:   alu_out = W'(alu_inp1 + alu_inp2);
         2'b01:   alu_out = W'(alu_inp1 - alu_inp2);
         2'b10:   alu_out = alu_inp1 & alu_inp2;
         default: alu_out = ~alu_inp2;
      endcase
   end

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Expected result, error, latency (edges incl. acceptance) and first ALU ctrl.
   task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] d, output logic err, output int lat,
                        output logic [1:0] ctrl1);
      err = 1'b0;
      d = '0;
      lat = 2;
      ctrl1 = op[1:0];
      case (op)
         3'd0: d = W'(int'(a) + int'(b));
         3'd1: d = W'(256 + int'(a) - int'(b));
         3'd2: d = a & b;
         3'd3: d = W'(255 - int'(b));
         3'd4: begin d = W'(256 - int'(a)); lat = 3; ctrl1 = 2'b11; end
`ifdef ALU_SEQ_MUL_EN
         3'd5: begin
            d = W'(int'(a) * int'(b));
            lat = (b == 0) ? 1 : int'(b) + 1;
            ctrl1 = 2'b00;
         end
`endif
         default: begin err = 1'b1; lat = 1; ctrl1 = 2'b00; end
      endcase
   endtask

   // Issue one command, check result/latency, optionally stall the consumer.
   task automatic do_cmd(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int stall);
      logic [W-1:0] e_data;
      logic         e_err;
      int           e_lat;
      logic [1:0]   e_ctrl1;
      logic [1:0]   ctrl1;
      logic [1:0]   ctrl2;
      int           lat;
      int           wait_n;
      model(op, a, b, e_data, e_err, e_lat, e_ctrl1);
      wait_n = 0;
      while (!cmd_ready && wait_n < 20) begin
         @(posedge clk); #1;
         wait_n++;
      end
      check_eq("cmd_ready_idle", 32'(cmd_ready), 1);
      cmd_valid = 1'b1;
      cmd_op = op;
      cmd_a = a;
      cmd_b = b;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cmd_a = W'($urandom);
      cmd_b = W'($urandom);
      lat = 1;
      ctrl1 = alu_ctrl;
      ctrl2 = 2'b00;
      while (!res_valid && lat < 400) begin
         @(posedge clk); #1;
         lat++;
         if (lat == 2) ctrl2 = alu_ctrl;
      end
      check_eq("latency", 32'(lat), 32'(e_lat));
      check_eq("res_data", 32'(res_data), 32'(e_data));
      check_eq("res_zero", 32'(res_zero), 32'(e_data == 0));
      check_eq("res_err", 32'(res_err), 32'(e_err));
      check_eq("ctrl_first", 32'(ctrl1), 32'(e_ctrl1));
      check_eq("cmd_ready_done", 32'(cmd_ready), 0);
      if (op == 3'd4) check_eq("neg_ctrl_second", 32'(ctrl2), 0);
      for (int k = 0; k < stall; k++) begin
         cmd_valid = 1'b1;
         cmd_op = 3'($urandom);
         @(posedge clk); #1;
         check_eq("stall_valid", 32'(res_valid), 1);
         check_eq("stall_data", 32'(res_data), 32'(e_data));
         check_eq("stall_err", 32'(res_err), 32'(e_err));
         check_eq("stall_ready", 32'(cmd_ready), 0);
      end
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      check_eq("valid_after_hs", 32'(res_valid), 0);
   endtask

   initial begin
      int seen;
      n_checks = 0;
      n_fail = 0;
      clk = 1'b0;
      rst = 1'b1;
      cmd_valid = 1'b0;
      cmd_op = '0;
      cmd_a = '0;
      cmd_b = '0;
      res_ready = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_cmd_ready", 32'(cmd_ready), 0);
      check_eq("rst_res_valid", 32'(res_valid), 0);
      check_eq("rst_res_data", 32'(res_data), 0);
      check_eq("rst_res_zero", 32'(res_zero), 0);
      check_eq("rst_res_err", 32'(res_err), 0);
      check_eq("rst_alu", 32'({alu_inp1, alu_inp2, alu_ctrl}), 0);
      rst = 1'b0;
      @(posedge clk); #1;
      check_eq("post_rst_ready", 32'(cmd_ready), 1);

      // Directed cases
      do_cmd(3'd0, 8'hF0, 8'h20, 0);
      do_cmd(3'd1, 8'h05, 8'h05, 0);
      do_cmd(3'd4, 8'h01, 8'h00, 0);
      do_cmd(3'd4, 8'h00, 8'h00, 0);
      do_cmd(3'd3, 8'h00, 8'h5A, 0);
      do_cmd(3'd5, 8'h13, 8'h0D, 0);
      do_cmd(3'd5, 8'h77, 8'h00, 0);
      do_cmd(3'd5, 8'h10, 8'h10, 0);
      do_cmd(3'd0, 8'h12, 8'h34, 5);
      do_cmd(3'd6, 8'h12, 8'h34, 0);
      do_cmd(3'd2, 8'hAA, 8'h0F, 0);
      do_cmd(3'd7, 8'hFF, 8'hFF, 1);

      // Randomized commands
      for (int i = 0; i < 40; i++) begin
         do_cmd(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), $urandom_range(0, 3));
      end

      // Reset in the middle of a long multiply: no result may survive it
      cmd_valid = 1'b1;
      cmd_op = 3'd5;
      cmd_a = 8'h13;
      cmd_b = 8'h40;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check_eq("midrst_valid", 32'(res_valid), 0);
      check_eq("midrst_ctrl", 32'(alu_ctrl), 0);
      check_eq("midrst_inp", 32'({alu_inp1, alu_inp2}), 0);
      check_eq("midrst_ready", 32'(cmd_ready), 0);
      rst = 1'b0;
      @(posedge clk); #1;
      check_eq("midrst_ready_after", 32'(cmd_ready), 1);
      seen = 0;
      for (int i = 0; i < 80; i++) begin
         if (res_valid) seen++;
         @(posedge clk); #1;
      end
      check_eq("midrst_no_stale", 32'(seen), 0);

      // Normal operation resumes afterwards
      do_cmd(3'd2, 8'hAA, 8'h0F, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
